// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready producers.
// Optional: define FIFO_ARB_ALMST_THROTTLE_EN to end a grant on any write made while fifo_almst_full=1.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 24,
  parameter int BURST_MAX = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  input  logic                      fifo_almst_full,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic [7:0]                burst_cnt
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  localparam logic [7:0]      BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic [ID_W-1:0] LAST_INIT  = ID_W'(NUM_REQ - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            grant_valid_q, grant_valid_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0] pick_id;
  logic            end_grant;

  // Scan downwards so the last hit is the closest requester after last_q.
  always_comb begin
    pick_id = last_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[ID_W'((int'(last_q) + i) % NUM_REQ)]) begin
        pick_id = ID_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    burst_cnt_d   = burst_cnt_q;
    last_d        = last_q;
    end_grant     = 1'b0;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_data_in  = req_data[grant_id_q*DATA_W +: DATA_W];

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          burst_cnt_d   = '0;
          state_d       = S_GRANT;
        end
      end
      S_GRANT: begin
        // Gating on reset guarantees no write lands in a cycle that abandons the grant.
        req_ready[grant_id_q] = !fifo_full && !reset;
        fifo_wr_en            = req_valid[grant_id_q] && !fifo_full && !reset;
        if (!req_valid[grant_id_q]) begin
          end_grant = 1'b1;
        end else if (fifo_wr_en) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (burst_cnt_q == BURST_LAST) end_grant = 1'b1;
`ifdef FIFO_ARB_ALMST_THROTTLE_EN
          if (fifo_almst_full) end_grant = 1'b1;
`endif
        end
        if (end_grant) begin
          last_d        = grant_id_q;
          grant_valid_d = 1'b0;
          burst_cnt_d   = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef FIFO_ARB_ALMST_THROTTLE_EN
  logic unused_almst_full;
  assign unused_almst_full = fifo_almst_full;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      last_q        <= LAST_INIT;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      last_q        <= last_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter: one row per clock, inputs and expected outputs per row.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 24;
`ifdef FIFO_ARB_ALMST_THROTTLE_EN
  localparam int THR_LEN = 1;
`else
  localparam int THR_LEN = 4;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  fifo_data_in;
  logic           fifo_wr_en;
  logic           fifo_full;
  logic           fifo_almst_full;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic [7:0]     burst_cnt;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_almst_full(fifo_almst_full),
    .grant_valid(grant_valid), .grant_id(grant_id), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  // Producer model: each requester emits base+n, advancing on its own handshake.
  int sent [NR];
  initial for (int i = 0; i < NR; i++) sent[i] = 0;

  function automatic logic [DW-1:0] base(input int i);
    return DW'((i << 16) | 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) sent[i] <= sent[i] + 1;
  end

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = base(i) + DW'(sent[i]);
  end

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic       almst;
    logic [3:0] ready;
    logic       wr;
    logic       gv;
    logic [1:0] gid;
    logic [7:0] bc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   row   = 0;
  int   exp_cnt [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  function automatic void add_row(input logic rst, input logic [3:0] valid, input logic full,
                                  input logic almst, input logic [3:0] ready, input logic wr,
                                  input logic gv, input logic [1:0] gid, input logic [7:0] bc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.full = full; v.almst = almst;
    v.ready = ready; v.wr = wr; v.gv = gv; v.gid = gid; v.bc = bc;
    vecs.push_back(v);
  endfunction

  function automatic void add_idle(input logic [3:0] valid, input logic [1:0] gid, input logic almst);
    add_row(1'b0, valid, 1'b0, almst, 4'b0000, 1'b0, 1'b0, gid, 8'd0);
  endfunction

  function automatic void add_gnt(input logic [3:0] valid, input logic full, input logic almst,
                                  input logic [1:0] gid, input logic [7:0] bc, input logic wr);
    logic [3:0] rdy;
    rdy = full ? 4'b0000 : (4'b0001 << gid);
    add_row(1'b0, valid, full, almst, rdy, wr, 1'b1, gid, bc);
  endfunction

  initial begin
    int edges;
    logic seen;

    for (int i = 0; i < NR; i++) exp_cnt[i] = 0;

    // Reset state, then a single requester: 4-write burst, one bubble, re-grant, drop.
    add_idle(4'b0000, 2'd0, 1'b0);
    add_idle(4'b0001, 2'd0, 1'b0);
    for (int b = 0; b < 4; b++) add_gnt(4'b0001, 1'b0, 1'b0, 2'd0, 8'(b), 1'b1);
    add_idle(4'b0001, 2'd0, 1'b0);
    add_gnt(4'b0001, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    add_gnt(4'b0000, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0);
    add_idle(4'b0000, 2'd0, 1'b0);

    // All four requesting after a reset: order 0,1,2,3,0.
    add_row(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
    add_idle(4'b1111, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) add_gnt(4'b1111, 1'b0, 1'b0, 2'(k % 4), 8'(b), 1'b1);
      add_idle((k == 4) ? 4'b0100 : 4'b1111, 2'(k % 4), 1'b0);
    end

    // Requester 2 stalled by fifo_full for 5 cycles after two writes.
    add_gnt(4'b0100, 1'b0, 1'b0, 2'd2, 8'd0, 1'b1);
    add_gnt(4'b0100, 1'b0, 1'b0, 2'd2, 8'd1, 1'b1);
    for (int s = 0; s < 5; s++) add_gnt(4'b0100, 1'b1, 1'b0, 2'd2, 8'd2, 1'b0);
    add_gnt(4'b0100, 1'b0, 1'b0, 2'd2, 8'd2, 1'b1);
    add_gnt(4'b0100, 1'b0, 1'b0, 2'd2, 8'd3, 1'b1);
    add_idle(4'b0000, 2'd2, 1'b0);

    // Requester 1 runs dry after one write; requester 3 is next.
    add_idle(4'b0010, 2'd2, 1'b0);
    add_gnt(4'b1010, 1'b0, 1'b0, 2'd1, 8'd0, 1'b1);
    add_gnt(4'b1000, 1'b0, 1'b0, 2'd1, 8'd1, 1'b0);
    add_idle(4'b1000, 2'd1, 1'b0);
    add_gnt(4'b1000, 1'b0, 1'b0, 2'd3, 8'd0, 1'b1);
    add_gnt(4'b0000, 1'b0, 1'b0, 2'd3, 8'd1, 1'b0);

    // Reset on the third write of requester 1's burst; requester 0 wins afterwards.
    add_idle(4'b0110, 2'd3, 1'b0);
    add_gnt(4'b0110, 1'b0, 1'b0, 2'd1, 8'd0, 1'b1);
    add_gnt(4'b0110, 1'b0, 1'b0, 2'd1, 8'd1, 1'b1);
    add_row(1'b1, 4'b0110, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 8'd2);
    add_idle(4'b0111, 2'd0, 1'b0);
    add_gnt(4'b0111, 1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    add_gnt(4'b0000, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0);

    // Almost-full held with requesters 0 and 1 active.
    add_idle(4'b0011, 2'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < THR_LEN; b++) add_gnt(4'b0011, 1'b0, 1'b1, (k == 0) ? 2'd1 : 2'd0, 8'(b), 1'b1);
      add_idle((k == 0) ? 4'b0011 : 4'b0000, (k == 0) ? 2'd1 : 2'd0, 1'b1);
    end

    reset = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_almst_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[r]) begin
      row             = r;
      reset           = vecs[r].rst;
      req_valid       = vecs[r].valid;
      fifo_full       = vecs[r].full;
      fifo_almst_full = vecs[r].almst;
      @(negedge clk);
      check("req_ready",   32'(req_ready),   32'(vecs[r].ready));
      check("onehot",      32'($countones(req_ready) <= 1), 32'd1);
      check("fifo_wr_en",  32'(fifo_wr_en),  32'(vecs[r].wr));
      check("grant_valid", 32'(grant_valid), 32'(vecs[r].gv));
      check("grant_id",    32'(grant_id),    32'(vecs[r].gid));
      check("burst_cnt",   32'(burst_cnt),   32'(vecs[r].bc));
      if (vecs[r].wr) begin
        check("fifo_data_in", 32'(fifo_data_in), 32'(base(vecs[r].gid) + DW'(exp_cnt[vecs[r].gid])));
        exp_cnt[vecs[r].gid]++;
      end
      @(posedge clk);
      #1;
    end

    // Latency from idle: requester 2 raises valid, first write must land on the 2nd edge.
    row = -1;
    reset = 1'b0; fifo_full = 1'b0; fifo_almst_full = 1'b0;
    req_valid = 4'b0100;
    edges = 1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (fifo_wr_en) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        edges++;
      end
    end
    check("latency_seen", 32'(seen), 32'd1);
    check("latency_edge", 32'(edges), 32'd2);
    check("latency_data", 32'(fifo_data_in), 32'(base(2) + DW'(exp_cnt[2])));
    @(posedge clk);
    #1;
    req_valid = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("final_gv", 32'(grant_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
